// File: rtl/blackparrot_fpga_host_mmio_pkt.sv
// blackparrot_fpga_host_mmio_pkt
// Packetised MMIO host bridge for BlackParrot on FPGA. Each I/O request is
// serialised into a host request FIFO as header, address and data words; read
// responses are reassembled from the host response FIFO into one 64b reply.
// Optional feature macro: BP_HOST_MMIO_READ_TIMEOUT_EN (read timeout with a
// sticky flag). Without it reads wait indefinitely and mmio_timeout_o is 0.
module blackparrot_fpga_host_mmio_pkt #(
  parameter int data_width_p      = 64,
  parameter int addr_width_p      = 64,
  parameter int fifo_data_width_p = 32,
  parameter int req_els_p         = 64,
  parameter int resp_els_p        = 64,
  parameter int timeout_cycles_p  = 4096
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  input  logic                         axi_v_i,
  input  logic                         axi_w_i,
  input  logic [2:0]                   axi_size_i,
  input  logic [addr_width_p-1:0]      axi_addr_i,
  input  logic [data_width_p-1:0]      axi_data_i,
  output logic                         axi_ready_and_o,
  output logic                         resp_v_o,
  output logic                         resp_w_o,
  output logic [data_width_p-1:0]      resp_data_o,
  input  logic                         resp_ready_and_i,
  output logic                         mmio_v_o,
  output logic [fifo_data_width_p-1:0] mmio_data_o,
  input  logic                         mmio_yumi_i,
  output logic [fifo_data_width_p-1:0] mmio_count_o,
  input  logic                         mmio_v_i,
  input  logic [fifo_data_width_p-1:0] mmio_data_i,
  output logic                         mmio_ready_and_o,
  output logic [fifo_data_width_p-1:0] mmio_resp_count_o,
  output logic                         mmio_timeout_o
);

  localparam int FW        = fifo_data_width_p;
  localparam int DW        = data_width_p;
  localparam int BEATS_MAX = DW / FW;
  localparam int BW        = $clog2(BEATS_MAX + 1);
  localparam int RQ_AW     = (req_els_p > 1) ? $clog2(req_els_p) : 1;
  localparam int RQ_CW     = $clog2(req_els_p + 1);
  localparam int RS_AW     = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int RS_CW     = $clog2(resp_els_p + 1);
  localparam int AWC       = (addr_width_p < FW) ? addr_width_p : FW;

  typedef enum logic [2:0] {
    e_hdr   = 3'd0,
    e_addr  = 3'd1,
    e_wdata = 3'd2,
    e_wresp = 3'd3,
    e_rdata = 3'd4,
    e_rresp = 3'd5
  } state_e;

  // Number of host words carrying an (8<<size)-bit payload, at least one.
  function automatic logic [BW-1:0] beats_f(input logic [1:0] sz);
    int bits_v;
    int n_v;
    bits_v = 8 << sz;
    n_v    = bits_v / FW;
    return (n_v < 1) ? BW'(1) : BW'(n_v);
  endfunction

  // Keeps only the (8<<size) low bits of a bus-packed payload.
  function automatic logic [63:0] size_mask_f(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Replicates the low (8<<size) bits across the 64b response.
  function automatic logic [63:0] fill_f(input logic [1:0] sz, input logic [63:0] v);
    case (sz)
      2'd0:    return {8{v[7:0]}};
      2'd1:    return {4{v[15:0]}};
      2'd2:    return {2{v[31:0]}};
      default: return v;
    endcase
  endfunction

  state_e             state_r, state_n_s;
  logic [BW-1:0]      beat_cnt_r;
  logic [DW-1:0]      rdata_r;
  logic [BW-1:0]      beats_s;
  logic               last_beat_s;
  logic [FW-1:0]      hdr_word_s, addr_word_s, wbeat_s;
  logic [DW-1:0]      wdata_packed_s;
  logic               req_enq_req_s, req_enq_s, req_deq_s, req_ready_s;
  logic [FW-1:0]      req_word_s;
  logic               resp_enq_s, resp_deq_s, resp_empty_s;
  logic [FW-1:0]      resp_head_s;
  logic               timeout_hit_s, timed_out_s;
  logic               unused_s;

  // Request FIFO storage and bookkeeping
  logic [FW-1:0]      req_mem_r [req_els_p];
  logic [RQ_AW-1:0]   req_wptr_r, req_rptr_r;
  logic [RQ_CW-1:0]   req_cnt_r;

  // Response FIFO storage and bookkeeping
  logic [FW-1:0]      resp_mem_r [resp_els_p];
  logic [RS_AW-1:0]   resp_wptr_r, resp_rptr_r;
  logic [RS_CW-1:0]   resp_cnt_r;

  assign unused_s = ^{axi_size_i, axi_addr_i};

  // ---------------------------------------------------------------------------
  // Request FIFO: a full FIFO still accepts a word when the head leaves in the
  // same cycle, so the occupancy holds at depth instead of stalling.
  assign req_deq_s    = mmio_yumi_i & (req_cnt_r != '0);
  assign req_ready_s  = (req_cnt_r != RQ_CW'(req_els_p)) | req_deq_s;
  assign req_enq_s    = req_enq_req_s & req_ready_s;
  assign mmio_v_o     = (req_cnt_r != '0);
  assign mmio_data_o  = req_mem_r[req_rptr_r];
  assign mmio_count_o = FW'(req_cnt_r);

  // Request FIFO word storage (no reset needed; validity tracked by count)
  always_ff @(posedge s_axi_aclk) begin
    if (req_enq_s) begin
      req_mem_r[req_wptr_r] <= req_word_s;
    end
  end

  // Request FIFO pointers and saturating occupancy counter
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      req_wptr_r <= '0;
      req_rptr_r <= '0;
      req_cnt_r  <= '0;
    end else begin
      if (req_enq_s) begin
        req_wptr_r <= (req_wptr_r == RQ_AW'(req_els_p - 1)) ? '0 : req_wptr_r + RQ_AW'(1);
      end
      if (req_deq_s) begin
        req_rptr_r <= (req_rptr_r == RQ_AW'(req_els_p - 1)) ? '0 : req_rptr_r + RQ_AW'(1);
      end
      case ({req_enq_s, req_deq_s})
        2'b10:   req_cnt_r <= (req_cnt_r == RQ_CW'(req_els_p)) ? req_cnt_r : req_cnt_r + RQ_CW'(1);
        2'b01:   req_cnt_r <= req_cnt_r - RQ_CW'(1);
        default: req_cnt_r <= req_cnt_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO: host pushes words, the FSM pops them in e_rdata.
  assign mmio_ready_and_o  = (resp_cnt_r != RS_CW'(resp_els_p));
  assign resp_enq_s        = mmio_v_i & mmio_ready_and_o;
  assign resp_empty_s      = (resp_cnt_r == '0);
  assign resp_head_s       = resp_mem_r[resp_rptr_r];
  assign mmio_resp_count_o = FW'(resp_cnt_r);

  // Response FIFO word storage
  always_ff @(posedge s_axi_aclk) begin
    if (resp_enq_s) begin
      resp_mem_r[resp_wptr_r] <= mmio_data_i;
    end
  end

  // Response FIFO pointers and occupancy counter
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      resp_wptr_r <= '0;
      resp_rptr_r <= '0;
      resp_cnt_r  <= '0;
    end else begin
      if (resp_enq_s) begin
        resp_wptr_r <= (resp_wptr_r == RS_AW'(resp_els_p - 1)) ? '0 : resp_wptr_r + RS_AW'(1);
      end
      if (resp_deq_s) begin
        resp_rptr_r <= (resp_rptr_r == RS_AW'(resp_els_p - 1)) ? '0 : resp_rptr_r + RS_AW'(1);
      end
      case ({resp_enq_s, resp_deq_s})
        2'b10:   resp_cnt_r <= (resp_cnt_r == RS_CW'(resp_els_p)) ? resp_cnt_r : resp_cnt_r + RS_CW'(1);
        2'b01:   resp_cnt_r <= resp_cnt_r - RS_CW'(1);
        default: resp_cnt_r <= resp_cnt_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Packet fields derived from the held request
  assign beats_s        = beats_f(axi_size_i[1:0]);
  assign last_beat_s    = (beat_cnt_r == (beats_s - BW'(1)));
  assign hdr_word_s     = FW'({axi_addr_i[2:0], axi_size_i[1:0], axi_w_i});
  assign addr_word_s    = FW'(axi_addr_i[AWC-1:0]);
  assign wdata_packed_s = (axi_data_i >> {axi_addr_i[2:0], 3'b000}) & size_mask_f(axi_size_i[1:0]);

  // Select the write beat for the current beat counter, low beat first
  always_comb begin
    wbeat_s = '0;
    for (int b = 0; b < BEATS_MAX; b++) begin
      wbeat_s = (beat_cnt_r == BW'(b)) ? wdata_packed_s[b*FW +: FW] : wbeat_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Read timeout (optional)
`ifdef BP_HOST_MMIO_READ_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles_p + 1);
  logic [TW-1:0] tcnt_r;
  logic          timed_out_r;
  logic          timeout_flag_r;

  assign timeout_hit_s  = (state_r == e_rdata) & resp_empty_s & (tcnt_r == TW'(timeout_cycles_p - 1));
  assign timed_out_s    = timed_out_r;
  assign mmio_timeout_o = timeout_flag_r;

  // Idle-wait counter, per-transaction timeout marker and sticky flag
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tcnt_r         <= '0;
      timed_out_r    <= 1'b0;
      timeout_flag_r <= 1'b0;
    end else begin
      if ((state_r == e_rdata) && resp_empty_s && !timeout_hit_s) begin
        tcnt_r <= tcnt_r + TW'(1);
      end else begin
        tcnt_r <= '0;
      end
      if (timeout_hit_s) begin
        timed_out_r <= 1'b1;
      end else if (state_r == e_hdr) begin
        timed_out_r <= 1'b0;
      end else begin
        timed_out_r <= timed_out_r;
      end
      timeout_flag_r <= timeout_flag_r | timeout_hit_s;
    end
  end
`else
  assign timeout_hit_s  = 1'b0;
  assign timed_out_s    = 1'b0;
  assign mmio_timeout_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r <= e_hdr;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state logic; every enqueue waits on request FIFO space
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      e_hdr:   state_n_s = (axi_v_i && req_ready_s) ? e_addr : e_hdr;
      e_addr:  state_n_s = req_ready_s ? (axi_w_i ? e_wdata : e_rdata) : e_addr;
      e_wdata: state_n_s = (req_ready_s && last_beat_s) ? e_wresp : e_wdata;
      e_wresp: state_n_s = resp_ready_and_i ? e_hdr : e_wresp;
      e_rdata: state_n_s = ((resp_deq_s && last_beat_s) || timeout_hit_s) ? e_rresp : e_rdata;
      e_rresp: state_n_s = resp_ready_and_i ? e_hdr : e_rresp;
      default: state_n_s = e_hdr;
    endcase
  end

  // FSM outputs: FIFO enqueue/dequeue requests and the response channel
  always_comb begin
    req_enq_req_s   = 1'b0;
    req_word_s      = '0;
    resp_deq_s      = 1'b0;
    resp_v_o        = 1'b0;
    resp_w_o        = 1'b0;
    resp_data_o     = '0;
    axi_ready_and_o = 1'b0;
    case (state_r)
      e_hdr: begin
        req_enq_req_s = axi_v_i;
        req_word_s    = hdr_word_s;
      end
      e_addr: begin
        req_enq_req_s = 1'b1;
        req_word_s    = addr_word_s;
      end
      e_wdata: begin
        req_enq_req_s = 1'b1;
        req_word_s    = wbeat_s;
      end
      e_wresp: begin
        resp_v_o        = 1'b1;
        resp_w_o        = 1'b1;
        axi_ready_and_o = resp_ready_and_i;
      end
      e_rdata: begin
        resp_deq_s = !resp_empty_s;
      end
      e_rresp: begin
        resp_v_o        = 1'b1;
        resp_data_o     = timed_out_s ? '1 : fill_f(axi_size_i[1:0], rdata_r);
        axi_ready_and_o = resp_ready_and_i;
      end
      default: begin
        req_enq_req_s = 1'b0;
      end
    endcase
  end

  // Beat counter for both directions and the read assembly register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      beat_cnt_r <= '0;
      rdata_r    <= '0;
    end else if ((state_r == e_wdata) && req_enq_s) begin
      beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BW'(1);
    end else if (resp_deq_s) begin
      for (int b = 0; b < BEATS_MAX; b++) begin
        if (beat_cnt_r == BW'(b)) begin
          rdata_r[b*FW +: FW] <= resp_head_s;
        end
      end
      beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BW'(1);
    end else if (state_r == e_hdr) begin
      beat_cnt_r <= '0;
    end
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_mmio_pkt.sv
// Scoreboard bench for blackparrot_fpga_host_mmio_pkt (32b host words).
// Stimulus pushes expected host words and responses into queues; monitors pop
// and compare on each mmio_v_o/mmio_yumi_i and resp_v_o/resp_ready_and_i handshake.
module tb_blackparrot_fpga_host_mmio_pkt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axi_v = 1'b0, axi_w = 1'b0;
  logic [2:0]  axi_size = 3'd0;
  logic [63:0] axi_addr = 64'd0, axi_data = 64'd0;
  logic        axi_ready;
  logic        resp_v, resp_w;
  logic [63:0] resp_data;
  logic        resp_ready = 1'b1;
  logic        mmio_v;
  logic [31:0] mmio_data;
  logic        mmio_yumi = 1'b1;
  logic [31:0] mmio_count;
  logic        host_v = 1'b0;
  logic [31:0] host_data = 32'd0;
  logic        host_ready;
  logic [31:0] resp_count;
  logic        timeout_flag;

  int tests = 0;
  int fails = 0;
  int cyc;

  logic [31:0] exp_mmio_q [$];
  logic [64:0] exp_resp_q [$];

  blackparrot_fpga_host_mmio_pkt #(
    .data_width_p(64), .addr_width_p(64), .fifo_data_width_p(32),
    .req_els_p(64), .resp_els_p(64), .timeout_cycles_p(16)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .axi_v_i(axi_v), .axi_w_i(axi_w), .axi_size_i(axi_size),
    .axi_addr_i(axi_addr), .axi_data_i(axi_data), .axi_ready_and_o(axi_ready),
    .resp_v_o(resp_v), .resp_w_o(resp_w), .resp_data_o(resp_data),
    .resp_ready_and_i(resp_ready),
    .mmio_v_o(mmio_v), .mmio_data_o(mmio_data), .mmio_yumi_i(mmio_yumi),
    .mmio_count_o(mmio_count),
    .mmio_v_i(host_v), .mmio_data_i(host_data), .mmio_ready_and_o(host_ready),
    .mmio_resp_count_o(resp_count), .mmio_timeout_o(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Host-side word monitor
  always @(negedge clk) begin
    if (rst_n && mmio_v && mmio_yumi) begin
      if (exp_mmio_q.size() == 0) begin
        check("mmio_word_unexpected", {33'd0, mmio_data}, 65'h1_FFFF_FFFF_FFFF_FFFF);
      end else begin
        check("mmio_word", {33'd0, mmio_data}, {33'd0, exp_mmio_q.pop_front()});
      end
    end
  end

  // Converter-side response monitor
  always @(negedge clk) begin
    if (rst_n && resp_v && resp_ready) begin
      if (exp_resp_q.size() == 0) begin
        check("resp_unexpected", {resp_w, resp_data}, 65'h1_FFFF_FFFF_FFFF_FFFE);
      end else begin
        check("resp", {resp_w, resp_data}, exp_resp_q.pop_front());
      end
    end
  end

  // Called at posedge+1: present a request and hold it
  task automatic issue(input logic w, input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d);
    axi_v = 1'b1; axi_w = w; axi_size = sz; axi_addr = a; axi_data = d;
  endtask

  // Wait (bounded) for the request handshake, then drop valid at posedge+1
  task automatic wait_ack(input string name, input int limit, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (axi_ready) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s: no handshake within %0d cycles", name, limit);
    end
    @(posedge clk); #1;
    axi_v = 1'b0;
  endtask

  // Called at posedge+1: host pushes one response word
  task automatic host_push(input logic [31:0] w);
    host_v = 1'b1; host_data = w;
    @(posedge clk); #1;
    host_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_v", {64'd0, resp_v}, 65'd0);
    check("rst_axi_ready", {64'd0, axi_ready}, 65'd0);
    check("rst_mmio_v", {64'd0, mmio_v}, 65'd0);
    check("rst_count", {33'd0, mmio_count}, 65'd0);
    check("rst_resp_count", {33'd0, resp_count}, 65'd0);
    check("rst_timeout", {64'd0, timeout_flag}, 65'd0);
    check("rst_host_ready", {64'd0, host_ready}, 65'd1);
    @(posedge clk); #1;

    // Write size 2 at 0x0010_0004: header = w | size<<1 | addr[2:0]<<3 = 0x25;
    // data >> 32 masked to 32b = 0xAABBCCDD.
    exp_mmio_q.push_back(32'h25); exp_mmio_q.push_back(32'h0010_0004);
    exp_mmio_q.push_back(32'hAABB_CCDD);
    exp_resp_q.push_back({1'b1, 64'd0});
    issue(1'b1, 3'd2, 64'h0010_0004, 64'hAABB_CCDD_1122_3344);
    wait_ack("wr_size2", 20, cyc);

    // 64b write: 4 enqueue cycles, response in cycle 5
    exp_mmio_q.push_back(32'h07); exp_mmio_q.push_back(32'h0);
    exp_mmio_q.push_back(32'h89AB_CDEF); exp_mmio_q.push_back(32'h0123_4567);
    exp_resp_q.push_back({1'b1, 64'd0});
    issue(1'b1, 3'd3, 64'h0, 64'h0123_4567_89AB_CDEF);
    wait_ack("wr_size3", 20, cyc);
    check("wr_size3_latency", 65'(cyc), 65'd5);

    // Write size 0 at 0x5: header 0x29, byte 5 of data = 0x33
    exp_mmio_q.push_back(32'h29); exp_mmio_q.push_back(32'h5);
    exp_mmio_q.push_back(32'h33);
    exp_resp_q.push_back({1'b1, 64'd0});
    issue(1'b1, 3'd0, 64'h5, 64'h1122_3344_5566_7788);
    wait_ack("wr_size0", 20, cyc);

    // Read size 3 at 0x8 with two pre-pushed host words
    host_push(32'h1111_1111);
    host_push(32'h2222_2222);
    check("resp_count_2", {33'd0, resp_count}, 65'd2);
    exp_mmio_q.push_back(32'h06); exp_mmio_q.push_back(32'h8);
    exp_resp_q.push_back({1'b0, 64'h2222_2222_1111_1111});
    issue(1'b0, 3'd3, 64'h8, 64'h0);
    wait_ack("rd_size3", 20, cyc);
    check("rd_size3_latency", 65'(cyc), 65'd5);

    // Read size 0 at 0x3: header 0x18, byte replicated
    host_push(32'h0000_005A);
    exp_mmio_q.push_back(32'h18); exp_mmio_q.push_back(32'h3);
    exp_resp_q.push_back({1'b0, 64'h5A5A_5A5A_5A5A_5A5A});
    issue(1'b0, 3'd0, 64'h3, 64'h0);
    wait_ack("rd_size0", 20, cyc);

    // Fill the request FIFO with the host stalled
    repeat (4) @(posedge clk);
    #1 mmio_yumi = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_mmio_q.push_back(32'h07); exp_mmio_q.push_back(32'h0);
      exp_mmio_q.push_back(32'hB000_0000 + 32'(i)); exp_mmio_q.push_back(32'hA000_0000 + 32'(i));
      exp_resp_q.push_back({1'b1, 64'd0});
      issue(1'b1, 3'd3, 64'h0, {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
      wait_ack("fill_wr", 20, cyc);
    end
    @(negedge clk);
    check("fill_count_64", {33'd0, mmio_count}, 65'd64);
    @(posedge clk); #1;
    exp_mmio_q.push_back(32'h07); exp_mmio_q.push_back(32'h0);
    exp_mmio_q.push_back(32'h9ABC_DEF0); exp_mmio_q.push_back(32'h1234_5678);
    exp_resp_q.push_back({1'b1, 64'd0});
    issue(1'b1, 3'd3, 64'h0, 64'h1234_5678_9ABC_DEF0);
    repeat (3) @(negedge clk);
    check("stall_count", {33'd0, mmio_count}, 65'd64);
    check("stall_no_ack", {64'd0, axi_ready}, 65'd0);
    @(posedge clk); #1 mmio_yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("simul_enq_deq_count", {33'd0, mmio_count}, 65'd64);
    @(posedge clk); #1;
    wait_ack("stall_wr", 20, cyc);
    cyc = 0;
    while (mmio_count != 32'd0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_count", {33'd0, mmio_count}, 65'd0);
    @(posedge clk); #1;

`ifdef BP_HOST_MMIO_READ_TIMEOUT_EN
    // Read size 2 at 0x10 with no host reply: header 0x04
    exp_mmio_q.push_back(32'h04); exp_mmio_q.push_back(32'h10);
    exp_resp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    issue(1'b0, 3'd2, 64'h10, 64'h0);
    wait_ack("rd_timeout", 40, cyc);
    check("timeout_latency", 65'(cyc), 65'd19);
    check("timeout_flag", {64'd0, timeout_flag}, 65'd1);
`endif

    // Reset in the middle of the write data phase
    exp_mmio_q.push_back(32'h07); exp_mmio_q.push_back(32'h0);
    issue(1'b1, 3'd3, 64'h0, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    axi_v = 1'b0;
    #1;
    check("midrst_resp_v", {64'd0, resp_v}, 65'd0);
    check("midrst_mmio_v", {64'd0, mmio_v}, 65'd0);
    check("midrst_count", {33'd0, mmio_count}, 65'd0);
    check("midrst_axi_ready", {64'd0, axi_ready}, 65'd0);
    check("midrst_timeout", {64'd0, timeout_flag}, 65'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_resp_v", {64'd0, resp_v}, 65'd0);
    check("postrst_host_ready", {64'd0, host_ready}, 65'd1);
    @(posedge clk); #1;

    // Recovery read size 2 at 0x4: header 0x24
    host_push(32'hCAFE_F00D);
    exp_mmio_q.push_back(32'h24); exp_mmio_q.push_back(32'h4);
    exp_resp_q.push_back({1'b0, 64'hCAFE_F00D_CAFE_F00D});
    issue(1'b0, 3'd2, 64'h4, 64'h0);
    wait_ack("rd_recover", 20, cyc);
    repeat (4) @(negedge clk);

    check("mmio_q_empty", 65'(exp_mmio_q.size()), 65'd0);
    check("resp_q_empty", 65'(exp_resp_q.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
